// File: rtl/imem_dmem_loader_pkg.sv
// Shared types for the boot loader: state encoding, count width and state decode helpers.
package imem_dmem_loader_pkg;
  localparam int LDR_CNT_WIDTH = 9;

  typedef enum logic [2:0] {
    LDR_IDLE   = 3'd0,
    LDR_LOAD_D = 3'd1,
    LDR_LOAD_I = 3'd2,
    LDR_RUN    = 3'd3,
    LDR_HALTED = 3'd4
  } ldr_state_e;

  function automatic logic ldr_loading(ldr_state_e s);
    return (s == LDR_LOAD_D) || (s == LDR_LOAD_I);
  endfunction

  // Core owns the data BRAM port once loading has finished, halted or not.
  function automatic logic ldr_core_owns(ldr_state_e s);
    return (s == LDR_RUN) || (s == LDR_HALTED);
  endfunction
endpackage

// File: rtl/imem_dmem_loader_if.sv
// Word stream into the boot loader (valid/ready).
interface imem_dmem_loader_if #(parameter int DATA_WIDTH = 32);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;

  modport master (output s_valid, s_data, input s_ready);
  modport slave  (input s_valid, s_data, output s_ready);
endinterface

// File: rtl/ldr_word_writer.sv
// Turns accepted stream words into one-cycle BRAM write pulses at idx*4, counting words.
module ldr_word_writer
  import imem_dmem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [LDR_CNT_WIDTH-1:0] count,
  input  logic                     accept,
  input  logic [DATA_WIDTH-1:0]    data,
  output logic                     last,
  output logic [ADDR_WIDTH-1:0]    w_addr,
  output logic [DATA_WIDTH-1:0]    w_dat,
  output logic                     w_enb
);
  localparam logic [LDR_CNT_WIDTH-1:0] ONE = LDR_CNT_WIDTH'(1);

  logic [LDR_CNT_WIDTH-1:0] idx, cnt;

  assign last = accept && ((idx + ONE) == cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx    <= '0;
      cnt    <= '0;
      w_addr <= '0;
      w_dat  <= '0;
      w_enb  <= 1'b0;
    end else begin
      w_enb <= accept;
      if (load) begin
        cnt <= count;
        idx <= '0;
      end else if (accept) begin
        idx    <= idx + ONE;
        w_addr <= ADDR_WIDTH'({idx, 2'b00});
        w_dat  <= data;
      end
    end
  end
endmodule

// File: rtl/imem_dmem_loader.sv
// Boot sequencer: streams data words then instruction words into BRAM, then releases the core.
module imem_dmem_loader
  import imem_dmem_loader_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int I_WORDS_MAX = 256,
  parameter int D_WORDS_MAX = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LDR_CNT_WIDTH-1:0] d_count,
  input  logic [LDR_CNT_WIDTH-1:0] i_count,
  input  logic                     halt_req,
  imem_dmem_loader_if.slave        s,
  output logic [ADDR_WIDTH-1:0]    d_w_addr,
  output logic [DATA_WIDTH-1:0]    d_w_dat,
  output logic                     d_w_enb,
  output logic [ADDR_WIDTH-1:0]    i_w_addr,
  output logic [DATA_WIDTH-1:0]    i_w_dat,
  output logic                     i_w_enb,
  output logic                     d_bram_init_done,
  output logic                     pc_stall,
  output logic                     i_r_enb,
  output logic                     rd_enbl,
  output logic                     busy,
  output logic                     error
);
  localparam logic [LDR_CNT_WIDTH-1:0] D_MAX = LDR_CNT_WIDTH'(D_WORDS_MAX);
  localparam logic [LDR_CNT_WIDTH-1:0] I_MAX = LDR_CNT_WIDTH'(I_WORDS_MAX);

  ldr_state_e state, nxt;
  logic s_ready_q, i_empty;
  logic bad, can_start, go, d_acc, i_acc, d_last, i_last;

  assign s.s_ready = s_ready_q;
  assign bad       = (d_count > D_MAX) || (i_count > I_MAX);
  assign can_start = (state == LDR_IDLE) || (state == LDR_HALTED);
  assign go        = start && can_start && !bad;
  assign d_acc     = s.s_valid && s_ready_q && (state == LDR_LOAD_D);
  assign i_acc     = s.s_valid && s_ready_q && (state == LDR_LOAD_I);

  ldr_word_writer #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_d_wr (
    .clk(clk), .rst(rst), .load(go), .count(d_count), .accept(d_acc), .data(s.s_data),
    .last(d_last), .w_addr(d_w_addr), .w_dat(d_w_dat), .w_enb(d_w_enb)
  );

  ldr_word_writer #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_i_wr (
    .clk(clk), .rst(rst), .load(go), .count(i_count), .accept(i_acc), .data(s.s_data),
    .last(i_last), .w_addr(i_w_addr), .w_dat(i_w_dat), .w_enb(i_w_enb)
  );

  always_comb begin
    nxt = state;
    case (state)
      LDR_IDLE, LDR_HALTED:
        if (go) begin
          if (d_count != '0)      nxt = LDR_LOAD_D;
          else if (i_count != '0) nxt = LDR_LOAD_I;
          else                    nxt = LDR_RUN;
        end
      LDR_LOAD_D: if (d_last) nxt = i_empty ? LDR_RUN : LDR_LOAD_I;
      LDR_LOAD_I: if (i_last) nxt = LDR_RUN;
      LDR_RUN:    if (halt_req) nxt = LDR_HALTED;
      default:    nxt = LDR_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state,
  // keeping the port select aligned with the final write pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= LDR_IDLE;
      i_empty          <= 1'b1;
      s_ready_q        <= 1'b0;
      busy             <= 1'b0;
      d_bram_init_done <= 1'b0;
      pc_stall         <= 1'b1;
      i_r_enb          <= 1'b0;
      rd_enbl          <= 1'b0;
      error            <= 1'b0;
    end else begin
      state            <= nxt;
      s_ready_q        <= ldr_loading(nxt);
      busy             <= ldr_loading(nxt);
      d_bram_init_done <= ldr_core_owns(nxt);
      rd_enbl          <= ldr_core_owns(nxt);
      i_r_enb          <= (nxt == LDR_RUN);
      pc_stall         <= (nxt != LDR_RUN);
      if (start && can_start) error <= bad;
      if (go) i_empty <= (i_count == '0);
    end
  end
endmodule

// File: tb/tb_imem_dmem_loader.sv
// Randomized scoreboard bench for the boot loader: expected BRAM writes queued by the driver,
// popped by a monitor on every write pulse; control outputs checked against a phase model.
module tb_imem_dmem_loader;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, halt_req = 1'b0;
  logic [8:0]  d_count = '0, i_count = '0;
  logic [9:0]  d_w_addr, i_w_addr;
  logic [31:0] d_w_dat, i_w_dat;
  logic        d_w_enb, i_w_enb, d_bram_init_done, pc_stall, i_r_enb, rd_enbl, busy, error;

  imem_dmem_loader_if #(.DATA_WIDTH(32)) s_if ();

  imem_dmem_loader dut (
    .clk(clk), .rst(rst), .start(start), .d_count(d_count), .i_count(i_count),
    .halt_req(halt_req), .s(s_if),
    .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
    .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
    .d_bram_init_done(d_bram_init_done), .pc_stall(pc_stall), .i_r_enb(i_r_enb),
    .rd_enbl(rd_enbl), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_i; logic [9:0] addr; logic [31:0] data; } wr_t;
  wr_t sb[$];
  int  vectors = 0, miscompares = 0;
  int  phase = 0;       // 0 idle, 1 loading, 2 run, 3 halted
  bit  exp_err = 1'b0;

  wr_t        m_e;
  logic [9:0] m_addr;
  logic [31:0] m_dat;

  always @(negedge clk) begin
    if (rst && (d_w_enb || i_w_enb)) begin
      vectors++;
      m_addr = i_w_enb ? i_w_addr : d_w_addr;
      m_dat  = i_w_enb ? i_w_dat : d_w_dat;
      if (d_w_enb && i_w_enb) begin
        miscompares++;
        $display("FAIL dual_write: both d_w_enb and i_w_enb high at %0t", $time);
      end else if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: is_i=%0d addr=%h dat=%h, none expected", i_w_enb, m_addr, m_dat);
      end else begin
        m_e = sb.pop_front();
        if (m_e.is_i !== i_w_enb || m_e.addr !== m_addr || m_e.data !== m_dat) begin
          miscompares++;
          $display("FAIL write: got is_i=%0d addr=%h dat=%h, want is_i=%0d addr=%h dat=%h",
                   i_w_enb, m_addr, m_dat, m_e.is_i, m_e.addr, m_e.data);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // {s_ready, busy, pc_stall, i_r_enb, rd_enbl, d_bram_init_done}
  task automatic chk_flags(input string nm);
    logic [5:0] exp;
    case (phase)
      1:       exp = 6'b111000;
      2:       exp = 6'b000111;
      3:       exp = 6'b001011;
      default: exp = 6'b001000;
    endcase
    chk(nm, {26'd0, s_if.s_ready, busy, pc_stall, i_r_enb, rd_enbl, d_bram_init_done}, {26'd0, exp});
    chk({nm, "_err"}, {31'd0, error}, {31'd0, exp_err});
  endtask

  task automatic apply_reset();
    s_if.s_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    sb.delete();
    phase = 0; exp_err = 1'b0;
    chk_flags("reset");
    chk("reset_wr", {d_w_enb, i_w_enb, d_w_addr, i_w_addr}, 32'd0);
    chk("reset_dat", d_w_dat | i_w_dat, 32'd0);
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic do_start(input int nd, input int ni);
    d_count = 9'(nd); i_count = 9'(ni);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (phase == 0 || phase == 3) begin
      if (nd > 256 || ni > 256) exp_err = 1'b1;
      else begin
        exp_err = 1'b0;
        phase = (nd + ni == 0) ? 2 : 1;
      end
    end
    chk_flags("after_start");
  endtask

  task automatic do_halt();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    if (phase == 2) phase = 3;
    chk_flags("halt");
  endtask

  // Streams nd data words then ni instruction words; stop_after >= 0 abandons the load early.
  task automatic stream(input int nd, input int ni, input bit gaps, input int stop_after);
    int cyc = 0;
    for (int k = 0; k < nd + ni; k++) begin
      wr_t e;
      int  n = 0;
      if (stop_after >= 0 && k == stop_after) return;
      if (gaps) begin
        s_if.s_valid = 1'b0;
        tick(); cyc++;
        chk("busy_gap", {31'd0, busy}, 32'd1);
      end
      e.is_i = (k >= nd);
      e.addr = 10'(((k < nd) ? k : k - nd) * 4);
      e.data = $urandom;
      sb.push_back(e);
      s_if.s_valid = 1'b1;
      s_if.s_data  = e.data;
      while (!s_if.s_ready && n < 50) begin tick(); n++; cyc++; end
      if (n == 50) begin
        miscompares++;
        $display("FAIL ready_timeout: word %0d never accepted", k);
        s_if.s_valid = 1'b0;
        return;
      end
      tick(); cyc++;
    end
    s_if.s_valid = 1'b0;
    phase = 2;
    chk_flags("run_entry");
    if (!gaps) chk("load_cycles", cyc, nd + ni);
    tick(); tick();
    chk("sb_drained", sb.size(), 32'd0);
  endtask

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    #12;
    apply_reset();

    // normal load, then start ignored in RUN
    do_start(2, 5); stream(2, 5, 1'b0, -1);
    do_start(1, 1);
    do_halt();

    // backpressure gaps
    do_start(2, 5); stream(2, 5, 1'b1, -1);
    do_halt();

    // zero counts
    do_start(0, 3); stream(0, 3, 1'b0, -1);
    do_halt();
    do_start(0, 0);
    do_halt();

    // rejected start while halted, then halt-and-reload one data word
    do_start(1, 257);
    do_start(1, 0); stream(1, 0, 1'b0, -1);

    // over-range from IDLE, followed by a valid start
    apply_reset();
    do_start(0, 257);
    do_start(257, 4);
    do_start(2, 5);

    // reset after 3 instruction words, then reload
    stream(2, 5, 1'b0, 5);
    apply_reset();
    do_start(2, 5); stream(2, 5, 1'b0, -1);

    // randomized loads
    for (int r = 0; r < 6; r++) begin
      int nd = $urandom_range(0, 8);
      int ni = $urandom_range(0, 8);
      bit g  = 1'($urandom_range(0, 1));
      do_halt();
      do_start(nd, ni); stream(nd, ni, g, -1);
    end

    // full capacity boundary
    do_halt();
    do_start(256, 256); stream(256, 256, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
